// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants, state type and sizing helpers for the fetch PC generator.
package fetch_pc_gen_pkg;

    localparam int ISSUE_WIDTH_DEF = 2;
    localparam int INSTR_BYTES_DEF = 4;
    localparam int GROUP_BYTES     = ISSUE_WIDTH_DEF * INSTR_BYTES_DEF;
    localparam int OFFSET_BITS     = $clog2(ISSUE_WIDTH_DEF);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    function automatic int group_bytes(int issue_width, int instr_bytes);
        return issue_width * instr_bytes;
    endfunction

    // A single-lane group still carries a 1-bit offset field, tied to zero.
    function automatic int offset_bits(int issue_width);
        return (issue_width > 1) ? $clog2(issue_width) : 1;
    endfunction

endpackage

// File: rtl/fetch_group_align.sv
// Splits a redirect target into a group-aligned base and the first valid lane.
module fetch_group_align
    import fetch_pc_gen_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ISSUE_WIDTH = 2,
    parameter int INSTR_BYTES = 4,
    parameter int OFF_W       = 1
) (
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] base,
    output logic [OFF_W-1:0] offset
);

    localparam int GB  = group_bytes(ISSUE_WIDTH, INSTR_BYTES);
    localparam int IBB = $clog2(INSTR_BYTES);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(GB - 1);

    // Sub-instruction address bits fall out of the shift and are dropped.
    assign base   = target & ~LOW_MASK;
    assign offset = (ISSUE_WIDTH > 1) ? OFF_W'((target & LOW_MASK) >> IBB) : '0;

endmodule

// File: rtl/fetch_pc_gen.sv
// N-wide fetch group PC generator with stall hold, flush and buffered predict redirect.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ISSUE_WIDTH = 2,
    parameter int INSTR_BYTES = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_f,
    input  logic                         flush_valid,
    input  logic [WIDTH-1:0]             flush_pc,
    input  logic                         pred_valid,
    input  logic [WIDTH-1:0]             pred_pc,
    output logic [ISSUE_WIDTH*WIDTH-1:0] pc_group,
    output logic [ISSUE_WIDTH-1:0]       lane_valid,
    output logic                         fetch_valid,
    output logic                         pred_pending
);

    localparam int GB    = group_bytes(ISSUE_WIDTH, INSTR_BYTES);
    localparam int OFF_W = offset_bits(ISSUE_WIDTH);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [OFF_W-1:0] k_q, k_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic [WIDTH-1:0] flush_base, pend_base, pred_base;
    logic [OFF_W-1:0] flush_k, pend_k, pred_k;

    fetch_group_align #(.WIDTH(WIDTH), .ISSUE_WIDTH(ISSUE_WIDTH), .INSTR_BYTES(INSTR_BYTES), .OFF_W(OFF_W))
        u_align_flush (.target(flush_pc),  .base(flush_base), .offset(flush_k));
    fetch_group_align #(.WIDTH(WIDTH), .ISSUE_WIDTH(ISSUE_WIDTH), .INSTR_BYTES(INSTR_BYTES), .OFF_W(OFF_W))
        u_align_pend  (.target(pend_pc_q), .base(pend_base),  .offset(pend_k));
    fetch_group_align #(.WIDTH(WIDTH), .ISSUE_WIDTH(ISSUE_WIDTH), .INSTR_BYTES(INSTR_BYTES), .OFF_W(OFF_W))
        u_align_pred  (.target(pred_pc),   .base(pred_base),  .offset(pred_k));

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        k_d       = k_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (state_q == BOOT) begin
            // RESET_PC becomes the first valid group; redirects here are dropped.
            state_d = RUN;
        end else if (flush_valid) begin
            base_d = flush_base;
            k_d    = flush_k;
            pend_d = 1'b0;
        end else if (stall_f) begin
            if (pred_valid) begin
                pend_d    = 1'b1;
                pend_pc_d = pred_pc;
            end
        end else if (pend_q) begin
            base_d = pend_base;
            k_d    = pend_k;
            pend_d = 1'b0;
        end else if (pred_valid) begin
            base_d = pred_base;
            k_d    = pred_k;
        end else begin
            base_d = base_q + WIDTH'(GB);
            k_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= BOOT;
            base_q    <= RESET_PC;
            k_q       <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            k_q       <= k_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign fetch_valid  = (state_q == RUN);
    assign pred_pending = pend_q;

    genvar i;
    generate
        for (i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
            assign pc_group[i*WIDTH +: WIDTH] = base_q + WIDTH'(i * INSTR_BYTES);
            assign lane_valid[i]              = (32'(i) >= 32'(k_q));
        end
    endgenerate

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus random traffic against an address-level model.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_f = 1'b0, flush_valid = 1'b0, pred_valid = 1'b0;
    logic [31:0] flush_pc = '0, pred_pc = '0;

    logic [63:0]  pc2;
    logic [1:0]   lv2;
    logic         fv2, pp2;
    logic [127:0] pc4;
    logic [3:0]   lv4;
    logic         fv4, pp4;

    int checks = 0;
    int errors = 0;

    fetch_pc_gen #(.WIDTH(32), .ISSUE_WIDTH(2), .INSTR_BYTES(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .flush_valid(flush_valid), .flush_pc(flush_pc),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pc_group(pc2), .lane_valid(lv2),
        .fetch_valid(fv2), .pred_pending(pp2));

    fetch_pc_gen #(.WIDTH(32), .ISSUE_WIDTH(4), .INSTR_BYTES(4), .RESET_PC(32'h0)) dut4 (
        .clk(clk), .rst(rst), .stall_f(stall_f), .flush_valid(flush_valid), .flush_pc(flush_pc),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pc_group(pc4), .lane_valid(lv4),
        .fetch_valid(fv4), .pred_pending(pp4));

    always #5 clk = ~clk;

    // Model: the current fetch target address per instance (0: 2 lanes, 1: 4 lanes).
    logic [31:0] m_t[2];
    bit          m_run, m_pend;
    logic [31:0] m_ppc;

    function automatic int gbytes(int d);
        return d ? 16 : 8;
    endfunction

    function automatic void model_reset();
        m_t[0] = 0; m_t[1] = 0; m_run = 0; m_pend = 0; m_ppc = 0;
    endfunction

    function automatic void model_step(bit s, bit f, logic [31:0] fpc, bit p, logic [31:0] ppc);
        logic [31:0] target;
        bit          jump = 1'b0;
        target = 0;
        if (!m_run) m_run = 1;
        else if (f) begin target = fpc; jump = 1; m_pend = 0; end
        else if (s) begin if (p) begin m_pend = 1; m_ppc = ppc; end end
        else if (m_pend) begin target = m_ppc; jump = 1; m_pend = 0; end
        else if (p) begin target = ppc; jump = 1; end
        else begin
            for (int d = 0; d < 2; d++)
                m_t[d] = m_t[d] - (m_t[d] % 32'(gbytes(d))) + 32'(gbytes(d));
        end
        if (jump) begin m_t[0] = target; m_t[1] = target; end
    endfunction

    function automatic logic [127:0] exp_pc(int d);
        logic [127:0] r = '0;
        logic [31:0]  b = m_t[d] - (m_t[d] % 32'(gbytes(d)));
        for (int i = 0; i < (d ? 4 : 2); i++) r[i*32 +: 32] = b + 32'(i * 4);
        return r;
    endfunction

    function automatic logic [3:0] exp_lv(int d);
        logic [3:0] r = '0;
        int k = int'((m_t[d] % 32'(gbytes(d))) / 4);
        for (int i = 0; i < (d ? 4 : 2); i++) r[i] = (i >= k);
        return r;
    endfunction

    task automatic step(input bit s, input bit f, input logic [31:0] fpc, input bit p, input logic [31:0] ppc);
        stall_f = s; flush_valid = f; flush_pc = fpc; pred_valid = p; pred_pc = ppc;
        @(posedge clk);
        model_step(s, f, fpc, p, ppc);
        #1;
        stall_f = 0; flush_valid = 0; pred_valid = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if (fv2 !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", fv2); end
        checks++; if (pc2 !== 64'h4_00000000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc2, 64'h4_00000000); end
        step(0, 0, 0, 0, 0);
        checks++; if (fv2 !== 1'b1) begin errors++; $display("FAIL boot_fv got=%b exp=1", fv2); end
        checks++; if (pc2 !== 64'h4_00000000) begin errors++; $display("FAIL boot_pc got=%h exp=%h", pc2, 64'h4_00000000); end
        checks++; if (lv2 !== 2'b11) begin errors++; $display("FAIL boot_lv got=%b exp=11", lv2); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc2 !== 64'hC_00000008) begin errors++; $display("FAIL seq_pc got=%h exp=%h", pc2, 64'hC_00000008); end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0, 0);
        checks++; if (pc2 !== 64'h14_00000010) begin errors++; $display("FAIL pre_stall_pc got=%h", pc2); end
        for (int c = 0; c < 3; c++) begin
            step(1, 0, 0, 0, 0);
            checks++; if (pc2 !== 64'h14_00000010) begin errors++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, pc2, 64'h14_00000010); end
        end
        step(0, 0, 0, 0, 0);
        checks++; if (pc2 !== 64'h1C_00000018) begin errors++; $display("FAIL stall_release got=%h exp=%h", pc2, 64'h1C_00000018); end
    endtask

    task automatic test_misaligned();
        step(0, 0, 0, 1, 32'h24);
        checks++; if (pc2 !== 64'h24_00000020) begin errors++; $display("FAIL mis_pc got=%h exp=%h", pc2, 64'h24_00000020); end
        checks++; if (lv2 !== 2'b10) begin errors++; $display("FAIL mis_lv got=%b exp=10", lv2); end
        checks++; if (lv4 !== 4'b1110) begin errors++; $display("FAIL mis_lv4 got=%b exp=1110", lv4); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc2 !== 64'h2C_00000028) begin errors++; $display("FAIL mis_next_pc got=%h exp=%h", pc2, 64'h2C_00000028); end
        checks++; if (lv2 !== 2'b11) begin errors++; $display("FAIL mis_next_lv got=%b exp=11", lv2); end
    endtask

    task automatic test_buffered_pred();
        step(1, 0, 0, 1, 32'h100);
        checks++; if (pp2 !== 1'b1) begin errors++; $display("FAIL buf_pend1 got=%b exp=1", pp2); end
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h200);
        checks++; if (pp2 !== 1'b1) begin errors++; $display("FAIL buf_pend2 got=%b exp=1", pp2); end
        checks++; if (pc2 !== 64'h2C_00000028) begin errors++; $display("FAIL buf_hold got=%h exp=%h", pc2, 64'h2C_00000028); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc2 !== 64'h204_00000200) begin errors++; $display("FAIL buf_release got=%h exp=%h", pc2, 64'h204_00000200); end
        checks++; if (pp2 !== 1'b0) begin errors++; $display("FAIL buf_clear got=%b exp=0", pp2); end
    endtask

    task automatic test_flush_priority();
        step(1, 0, 0, 1, 32'h200);
        step(1, 1, 32'h80, 0, 0);
        checks++; if (pc2 !== 64'h84_00000080) begin errors++; $display("FAIL flush_stall got=%h exp=%h", pc2, 64'h84_00000080); end
        checks++; if (pp2 !== 1'b0) begin errors++; $display("FAIL flush_pend got=%b exp=0", pp2); end
        step(0, 1, 32'h40, 1, 32'h300);
        checks++; if (pc2 !== 64'h44_00000040) begin errors++; $display("FAIL flush_vs_pred got=%h exp=%h", pc2, 64'h44_00000040); end
    endtask

    task automatic test_wrap();
        step(0, 1, 32'hFFFF_FFF0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++; if (pc4 !== 128'h0000000C_00000008_00000004_00000000) begin errors++; $display("FAIL wrap4 got=%h", pc4); end
        checks++; if (pc2 !== 64'hFFFFFFFC_FFFFFFF8) begin errors++; $display("FAIL wrap2_pre got=%h exp=%h", pc2, 64'hFFFFFFFC_FFFFFFF8); end
        step(0, 0, 0, 0, 0);
        checks++; if (pc2 !== 64'h4_00000000) begin errors++; $display("FAIL wrap2 got=%h exp=%h", pc2, 64'h4_00000000); end
    endtask

    task automatic test_random();
        int errs_here = 0;
        for (int n = 0; n < 300; n++) begin
            bit s = ($urandom_range(0, 9) < 3);
            bit f = ($urandom_range(0, 9) == 0);
            bit p = ($urandom_range(0, 9) < 3);
            logic [31:0] fpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            logic [31:0] ppc = $urandom;
            step(s, f, fpc, p, ppc);
            checks++;
            if (pc2 !== exp_pc(0)[63:0] || lv2 !== exp_lv(0)[1:0] || fv2 !== m_run || pp2 !== m_pend) begin
                errors++; errs_here++;
                if (errs_here < 5) $display("FAIL rand2 n=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", n,
                    pc2, lv2, fv2, pp2, exp_pc(0)[63:0], exp_lv(0)[1:0], m_run, m_pend);
            end
            checks++;
            if (pc4 !== exp_pc(1) || lv4 !== exp_lv(1) || fv4 !== m_run || pp4 !== m_pend) begin
                errors++; errs_here++;
                if (errs_here < 5) $display("FAIL rand4 n=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", n,
                    pc4, lv4, fv4, pp4, exp_pc(1), exp_lv(1), m_run, m_pend);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 1, 32'h500);
        checks++; if (pp2 !== 1'b1) begin errors++; $display("FAIL ar_pend_before got=%b exp=1", pp2); end
        rst = 0;
        #2;
        model_reset();
        checks++; if (fv2 !== 1'b0 || pp2 !== 1'b0) begin errors++; $display("FAIL ar_flags got=fv%b pp%b exp=fv0 pp0", fv2, pp2); end
        checks++; if (pc2 !== 64'h4_00000000 || lv2 !== 2'b11) begin errors++; $display("FAIL ar_pc2 got=%h/%b exp=%h/11", pc2, lv2, 64'h4_00000000); end
        checks++; if (pc4 !== 128'h0000000C_00000008_00000004_00000000 || lv4 !== 4'b1111) begin errors++; $display("FAIL ar_pc4 got=%h/%b", pc4, lv4); end
        @(negedge clk);
        rst = 1;
        step(0, 0, 0, 0, 0);
        checks++; if (pc2 !== 64'h4_00000000 || fv2 !== 1'b1 || pp2 !== 1'b0) begin errors++; $display("FAIL ar_restart got=%h/%b/%b exp=%h/1/0", pc2, fv2, pp2, 64'h4_00000000); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_misaligned();
        test_buffered_pred();
        test_flush_priority();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
